// File: rtl/vexrv_clint_if.sv
// rtl/vexrv_clint_if.sv - AXI-lite bus bundle between the data-bus crossbar and the CLINT
interface vexrv_clint_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] s_axil_awaddr;
   logic [2:0]        s_axil_awprot;
   logic              s_axil_awvalid;
   logic              s_axil_awready;
   logic [DATA_W-1:0] s_axil_wdata;
   logic [STRB_W-1:0] s_axil_wstrb;
   logic              s_axil_wvalid;
   logic              s_axil_wready;
   logic [1:0]        s_axil_bresp;
   logic              s_axil_bvalid;
   logic              s_axil_bready;
   logic [ADDR_W-1:0] s_axil_araddr;
   logic [2:0]        s_axil_arprot;
   logic              s_axil_arvalid;
   logic              s_axil_arready;
   logic [DATA_W-1:0] s_axil_rdata;
   logic [1:0]        s_axil_rresp;
   logic              s_axil_rvalid;
   logic              s_axil_rready;

   modport master (
      output s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
             s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid,
             s_axil_rready,
      input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
             s_axil_rdata, s_axil_rresp, s_axil_rvalid
   );

   modport slave (
      input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
             s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid,
             s_axil_rready,
      output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
             s_axil_rdata, s_axil_rresp, s_axil_rvalid
   );
endinterface

// File: rtl/vexrv_clint.sv
// rtl/vexrv_clint.sv - core-local interruptor: mtime, mtimecmp and msip behind an AXI-lite slave
module vexrv_clint #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int STRB_W   = DATA_W / 8,
   parameter int TICK_DIV = 1
) (
   input  logic         aclk,
   input  logic         aresetn,
   vexrv_clint_if.slave s_axil,
   output logic         timerInterrupt,
   output logic         softwareInterrupt
);

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

   localparam logic [13:0] OFF_MSIP    = 14'h0000;
   localparam logic [13:0] OFF_CMP_LO  = 14'h1000;
   localparam logic [13:0] OFF_CMP_HI  = 14'h1001;
   localparam logic [13:0] OFF_TIME_LO = 14'h2FFE;
   localparam logic [13:0] OFF_TIME_HI = 14'h2FFF;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam int          PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   wr_state_t         wr_state_q, wr_state_d;
   rd_state_t         rd_state_q, rd_state_d;
   logic              live_q;
   logic [1:0]        bresp_q, bresp_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              msip_q, msip_d;
   logic [63:0]       mtimecmp_q, mtimecmp_d;
   logic [63:0]       mtime_q, mtime_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic              timer_q;

   logic [ADDR_W-1:0] awaddr_w, araddr_w;
   logic [DATA_W-1:0] wdata_w;
   logic [STRB_W-1:0] wstrb_w;
   logic [13:0]       woff, roff;
   logic              wr_acc, rd_acc, tick;
   logic              unused_ok;

   assign awaddr_w = s_axil.s_axil_awaddr;
   assign araddr_w = s_axil.s_axil_araddr;
   assign wdata_w  = s_axil.s_axil_wdata;
   assign wstrb_w  = s_axil.s_axil_wstrb;
   assign woff     = awaddr_w[15:2];
   assign roff     = araddr_w[15:2];
   assign unused_ok = ^{s_axil.s_axil_awprot, s_axil.s_axil_arprot,
                        awaddr_w[ADDR_W-1:16], awaddr_w[1:0],
                        araddr_w[ADDR_W-1:16], araddr_w[1:0]};

   function automatic logic is_mapped(input logic [13:0] off);
      return (off == OFF_MSIP) || (off == OFF_CMP_LO) || (off == OFF_CMP_HI) ||
             (off == OFF_TIME_LO) || (off == OFF_TIME_HI);
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [STRB_W-1:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // live_q keeps every ready low until the first clock after reset release.
   assign wr_acc = live_q && (wr_state_q == WR_IDLE) && s_axil.s_axil_awvalid && s_axil.s_axil_wvalid;
   assign rd_acc = live_q && (rd_state_q == RD_IDLE) && s_axil.s_axil_arvalid;
   assign tick   = (presc_q == PRESC_LAST);

   assign s_axil.s_axil_awready = wr_acc;
   assign s_axil.s_axil_wready  = wr_acc;
   assign s_axil.s_axil_bvalid  = (wr_state_q == WR_RESP);
   assign s_axil.s_axil_bresp   = bresp_q;
   assign s_axil.s_axil_arready = live_q && (rd_state_q == RD_IDLE);
   assign s_axil.s_axil_rvalid  = (rd_state_q == RD_RESP);
   assign s_axil.s_axil_rdata   = rdata_q;
   assign s_axil.s_axil_rresp   = rresp_q;
   assign timerInterrupt        = timer_q;
   assign softwareInterrupt     = msip_q;

   // Write FSM: accept AW and W together, then hold the response until bready.
   always_comb begin
      wr_state_d = wr_state_q;
      bresp_d    = bresp_q;
      case (wr_state_q)
         WR_IDLE: if (wr_acc) begin
            wr_state_d = WR_RESP;
            bresp_d    = is_mapped(woff) ? RESP_OKAY : RESP_SLVERR;
         end
         WR_RESP: if (s_axil.s_axil_bready) wr_state_d = WR_IDLE;
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Read FSM: capture data from current register state on accept, hold until rready.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         RD_IDLE: if (rd_acc) begin
            rd_state_d = RD_RESP;
            rresp_d    = is_mapped(roff) ? RESP_OKAY : RESP_SLVERR;
            case (roff)
               OFF_MSIP:    rdata_d = {31'd0, msip_q};
               OFF_CMP_LO:  rdata_d = mtimecmp_q[31:0];
               OFF_CMP_HI:  rdata_d = mtimecmp_q[63:32];
               OFF_TIME_LO: rdata_d = mtime_q[31:0];
               OFF_TIME_HI: rdata_d = mtime_q[63:32];
               default:     rdata_d = 32'd0;
            endcase
         end
         RD_RESP: if (s_axil.s_axil_rready) rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Register next state: prescaled mtime tick, overridden by bus writes to either mtime half.
   always_comb begin
      presc_d    = tick ? '0 : presc_q + 1'b1;
      mtime_d    = mtime_q + 64'(tick);
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr_acc) begin
         case (woff)
            OFF_MSIP:    if (wstrb_w[0]) msip_d = wdata_w[0];
            OFF_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_w, wstrb_w);
            OFF_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_w, wstrb_w);
            OFF_TIME_LO: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_w, wstrb_w)};
            OFF_TIME_HI: mtime_d = {merge_bytes(mtime_q[63:32], wdata_w, wstrb_w), mtime_q[31:0]};
            default: ;
         endcase
      end
   end

   // State registers; the timer compare uses next-state values so it lands one clock after the change.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         live_q     <= 1'b0;
         bresp_q    <= 2'b00;
         rresp_q    <= 2'b00;
         rdata_q    <= 32'd0;
         msip_q     <= 1'b0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         mtime_q    <= 64'd0;
         presc_q    <= '0;
         timer_q    <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         live_q     <= 1'b1;
         bresp_q    <= bresp_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         msip_q     <= msip_d;
         mtimecmp_q <= mtimecmp_d;
         mtime_q    <= mtime_d;
         presc_q    <= presc_d;
         timer_q    <= (mtime_d >= mtimecmp_d);
      end
   end

endmodule

// File: tb/tb_vexrv_clint.sv
// tb/tb_vexrv_clint.sv - scoreboard bench for vexrv_clint against a cycle-count reference model
module tb_vexrv_clint;
   localparam int TICK_DIV = 1;

   logic aclk = 1'b0;
   logic aresetn;
   logic timer_irq, sw_irq;

   vexrv_clint_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   vexrv_clint #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .TICK_DIV(TICK_DIV)) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .s_axil           (bus.slave),
      .timerInterrupt   (timer_irq),
      .softwareInterrupt(sw_irq)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: mtime = value last written + number of ticks since, where edge k ticks when k % TICK_DIV == 0.
   longint      edges;
   logic [63:0] m_base;
   longint      m_base_e;
   logic [63:0] m_cmp;
   logic        m_msip;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) edges <= 0;
      else          edges <= edges + 1;
   end

   function automatic logic [63:0] m_time(input longint e);
      longint ticks;
      ticks = e / TICK_DIV - m_base_e / TICK_DIV;
      return m_base + 64'(ticks);
   endfunction

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [33:0] m_read(input logic [31:0] a, input longint e);
      logic [63:0] t;
      t = m_time(e);
      case (a[15:2])
         14'h0000: return {2'b00, 31'd0, m_msip};
         14'h1000: return {2'b00, m_cmp[31:0]};
         14'h1001: return {2'b00, m_cmp[63:32]};
         14'h2FFE: return {2'b00, t[31:0]};
         14'h2FFF: return {2'b00, t[63:32]};
         default:  return {2'b10, 32'd0};
      endcase
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input longint e, output logic [1:0] resp);
      logic [63:0] t;
      t = m_time(e - 1);
      resp = 2'b00;
      case (a[15:2])
         14'h0000: if (s[0]) m_msip = d[0];
         14'h1000: m_cmp[31:0]  = mrg(m_cmp[31:0], d, s);
         14'h1001: m_cmp[63:32] = mrg(m_cmp[63:32], d, s);
         14'h2FFE: begin m_base = {t[63:32], mrg(t[31:0], d, s)}; m_base_e = e; end
         14'h2FFF: begin m_base = {mrg(t[63:32], d, s), t[31:0]}; m_base_e = e; end
         default:  resp = 2'b10;
      endcase
   endtask

   task automatic m_reset();
      m_base = 64'd0; m_base_e = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0;
   endtask

   logic [1:0]  bq[$];
   logic [33:0] rq[$];
   bit hold_b = 1'b0;
   bit hold_r = 1'b0;

   // Response readies: random back-pressure, forced low while a stall is being examined.
   initial begin
      bus.s_axil_bready = 1'b0;
      bus.s_axil_rready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         bus.s_axil_bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
         bus.s_axil_rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: interrupt levels every cycle, B/R responses popped from the scoreboard on handshake.
   initial begin
      logic [33:0] rx;
      forever begin
         @(negedge aclk); #2;
         if (aresetn) begin
            check("timerInterrupt", 64'(timer_irq), 64'(m_time(edges) >= m_cmp));
            check("softwareInterrupt", 64'(sw_irq), 64'(m_msip));
            if (bus.s_axil_bvalid && bus.s_axil_bready) begin
               if (bq.size() == 0) check("unexpected_b", 64'(1), 64'(0));
               else check("bresp", 64'(bus.s_axil_bresp), 64'(bq.pop_front()));
            end
            if (bus.s_axil_rvalid && bus.s_axil_rready) begin
               if (rq.size() == 0) check("unexpected_r", 64'(1), 64'(0));
               else begin
                  rx = rq.pop_front();
                  check("rdata", 64'(bus.s_axil_rdata), 64'(rx[31:0]));
                  check("rresp", 64'(bus.s_axil_rresp), 64'(rx[33:32]));
               end
            end
         end
      end
   end

   task automatic xact(input bit dw, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                       input bit dr, input logic [31:0] ra);
      bit wdone, rdone, aw_acc, ar_acc;
      int guard;
      logic [1:0] br;
      wdone = !dw; rdone = !dr; guard = 0;
      @(negedge aclk);
      if (dw) begin
         bus.s_axil_awaddr = wa; bus.s_axil_wdata = wd; bus.s_axil_wstrb = ws;
         bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1;
      end
      if (dr) begin bus.s_axil_araddr = ra; bus.s_axil_arvalid = 1'b1; end
      while (!(wdone && rdone) && guard < 60) begin
         #1;
         aw_acc = bus.s_axil_awvalid && bus.s_axil_awready && bus.s_axil_wvalid && bus.s_axil_wready;
         ar_acc = bus.s_axil_arvalid && bus.s_axil_arready;
         @(negedge aclk);
         if (ar_acc) begin
            rq.push_back(m_read(ra, edges - 1));
            bus.s_axil_arvalid = 1'b0; rdone = 1'b1;
         end
         if (aw_acc) begin
            m_write(wa, wd, ws, edges, br);
            bq.push_back(br);
            bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0; wdone = 1'b1;
         end
         guard++;
      end
      if (!(wdone && rdone)) begin
         check("accept_timeout", 64'(1), 64'(0));
         bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0; bus.s_axil_arvalid = 1'b0;
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((bq.size() != 0 || rq.size() != 0) && guard < 100) begin
         @(negedge aclk); guard++;
      end
      if (bq.size() != 0 || rq.size() != 0) begin
         check("drain_timeout", 64'(1), 64'(0));
         bq.delete(); rq.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int guard;
      logic [31:0] snap;
      logic [1:0] br;
      logic [31:0] a, d, ra;
      logic [3:0]  s;
      int op;

      bus.s_axil_awaddr = '0; bus.s_axil_awprot = '0; bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wdata = '0; bus.s_axil_wstrb = '0; bus.s_axil_wvalid = 1'b0;
      bus.s_axil_araddr = '0; bus.s_axil_arprot = '0; bus.s_axil_arvalid = 1'b0;
      aresetn = 1'b0;
      m_reset();
      repeat (3) @(negedge aclk);
      #1;
      check("rst_awready", 64'(bus.s_axil_awready), 0);
      check("rst_arready", 64'(bus.s_axil_arready), 0);
      check("rst_bvalid",  64'(bus.s_axil_bvalid), 0);
      check("rst_rvalid",  64'(bus.s_axil_rvalid), 0);
      check("rst_resp_data", {30'd0, bus.s_axil_bresp, bus.s_axil_rresp, bus.s_axil_rdata}, 0);
      check("rst_irqs", 64'({timer_irq, sw_irq}), 0);
      @(negedge aclk);
      aresetn = 1'b1;

      // Idle count, then mtime low word and mtimecmp high word.
      repeat (10) @(negedge aclk);
      xact(0, 0, 0, 0, 1, 32'hBFF8);
      xact(0, 0, 0, 0, 1, 32'h4004);

      // Timer compare around 0x20.
      xact(1, 32'h4004, 32'h0, 4'hF, 0, 0);
      xact(1, 32'hBFF8, 32'h0, 4'hF, 0, 0);
      xact(1, 32'h4000, 32'h20, 4'hF, 0, 0);
      guard = 0;
      while (m_time(edges) != 64'h1F && guard < 100) begin @(negedge aclk); guard++; end
      #1 check("timer_before_cmp", 64'(timer_irq), 0);
      @(negedge aclk);
      #1 check("timer_at_cmp", 64'(timer_irq), 1);
      repeat (4) @(negedge aclk);
      xact(1, 32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0);
      repeat (3) @(negedge aclk);

      // Carry into high word, then 64-bit wrap.
      xact(1, 32'hBFFC, 32'h0, 4'hF, 0, 0);
      xact(1, 32'hBFF8, 32'hFFFF_FFFE, 4'hF, 0, 0);
      repeat (3) @(negedge aclk);
      xact(0, 0, 0, 0, 1, 32'hBFFC);
      xact(1, 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0);
      xact(1, 32'hBFF8, 32'hFFFF_FFF8, 4'hF, 0, 0);
      repeat (12) @(negedge aclk);
      xact(0, 0, 0, 0, 1, 32'hBFFC);
      xact(0, 0, 0, 0, 1, 32'hBFF8);

      // Software interrupt and a no-strobe write.
      xact(1, 32'h0, 32'h1, 4'b0001, 0, 0);
      xact(1, 32'h0, 32'h0, 4'b0000, 1, 32'h0);
      drain();

      // Unmapped offset with both responses stalled; a second request must not be accepted.
      hold_b = 1'b1; hold_r = 1'b1;
      xact(1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 1, 32'h1000);
      snap = bus.s_axil_rdata;
      bus.s_axil_awaddr = 32'h0; bus.s_axil_wdata = 32'h0; bus.s_axil_wstrb = 4'hF;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1;
      bus.s_axil_araddr = 32'h4000; bus.s_axil_arvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_bvalid", 64'({bus.s_axil_bvalid, bus.s_axil_bresp}), 64'(3'b110));
         check("stall_rvalid", 64'({bus.s_axil_rvalid, bus.s_axil_rresp}), 64'(3'b110));
         check("stall_rdata", 64'(bus.s_axil_rdata), 64'(snap));
         check("stall_no_accept", 64'({bus.s_axil_awready, bus.s_axil_arready}), 0);
         @(negedge aclk);
      end
      bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0; bus.s_axil_arvalid = 1'b0;
      hold_b = 1'b0; hold_r = 1'b0;
      drain();

      // AW without W is never accepted alone.
      @(negedge aclk);
      bus.s_axil_awaddr = 32'h0; bus.s_axil_wdata = 32'h0; bus.s_axil_wstrb = 4'b0001;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 check("aw_alone", 64'({bus.s_axil_awready, bus.s_axil_wready}), 0);
         @(negedge aclk);
      end
      bus.s_axil_wvalid = 1'b1;
      #1 check("aw_w_together", 64'({bus.s_axil_awready, bus.s_axil_wready}), 64'(2'b11));
      @(negedge aclk);
      m_write(32'h0, 32'h0, 4'b0001, edges, br);
      bq.push_back(br);
      bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;

      // Same-cycle read and write to one register: read sees the old value.
      xact(1, 32'h4000, 32'h1234_5678, 4'hF, 1, 32'h4000);
      xact(0, 0, 0, 0, 1, 32'h4000);

      // Randomized mix.
      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 2);
         case ($urandom_range(0, 6))
            0: a = 32'h0;  1: a = 32'h4000; 2: a = 32'h4004; 3: a = 32'hBFF8;
            4: a = 32'hBFFC; 5: a = 32'h1000; default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: ra = 32'h0; 1: ra = 32'h4000; 2: ra = 32'hBFF8; 3: ra = 32'hBFFC; default: ra = $urandom;
         endcase
         a = a | 32'($urandom_range(0, 3));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         xact(op != 1, a, d, s, op != 0, ra);
      end
      drain();

      // Reset during a pending write response.
      xact(1, 32'h0, 32'h1, 4'b0001, 0, 0);
      drain();
      hold_b = 1'b1;
      xact(1, 32'h4004, 32'h55, 4'hF, 0, 0);
      #1 check("b_pending", 64'(bus.s_axil_bvalid), 1);
      aresetn = 1'b0;
      #1;
      check("rst_abort_bvalid", 64'(bus.s_axil_bvalid), 0);
      check("rst_abort_irqs", 64'({timer_irq, sw_irq}), 0);
      m_reset();
      bq.delete(); rq.delete();
      hold_b = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      xact(0, 0, 0, 0, 1, 32'h4004);
      xact(0, 0, 0, 0, 1, 32'h0);
      xact(0, 0, 0, 0, 1, 32'hBFF8);
      drain();
      repeat (3) @(negedge aclk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
